jk_multimode_register: RTL

- Parametrised, WIDTH-bit bank of JK flip-flops sharing one clock and reset.
- Generalises the single-bit JK flip-flop with per-bit J/K plus three word-level modes: parallel load, up/down count and bidirectional shift.
- Adds a registered change mask, a terminal-count flag and a serial output, so the block can serve as a control register, counter or shifter in sequential-circuit designs.

---
 rtl/jk_multimode_register_if.sv | 37 +++
 rtl/jk_multimode_register.sv | 77 +++++++
 2 files changed

// File: rtl/jk_multimode_register_if.sv
`default_nettype none
// ============================================================================
// Module   : jk_multimode_register_if
// Purpose  : Bundles the control, data and status signals of the
//            jk_multimode_register bank. The clock and reset stay as plain
//            ports on the register itself.
// Ports    : master modport drives en/mode/j/k/d/dir/sin and observes
//            q/qb/chg/tc/sout; slave modport is the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface jk_multimode_register_if #(
    parameter int WIDTH = 8
) ();
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic             dir;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] chg;
    logic             tc;
    logic             sout;

    modport master (
        output en, mode, j, k, d, dir, sin,
        input  q, qb, chg, tc, sout
    );

    modport slave (
        input  en, mode, j, k, d, dir, sin,
        output q, qb, chg, tc, sout
    );
endinterface
`default_nettype wire

// File: rtl/jk_multimode_register.sv
`default_nettype none
// ============================================================================
// Module   : jk_multimode_register
// Purpose  : WIDTH-bit bank of JK flip-flops with word-level parallel load,
//            up/down count and bidirectional shift modes, plus a registered
//            change mask, terminal-count flag and serial output.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-low reset
//            bus  - slave modport of jk_multimode_register_if:
//                   en, mode(0=JK,1=LOAD,2=COUNT,3=SHIFT), j, k, d, dir, sin
//                   in; q, qb, chg, tc, sout out
// Params   : WIDTH   - number of bit cells (minimum 2)
//            RST_VAL - value of q while reset is asserted
// Revision : 1.0 - initial release
// ============================================================================
module jk_multimode_register #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    jk_multimode_register_if.slave bus
);

    localparam logic [1:0]       c_mode_jk    = 2'd0;
    localparam logic [1:0]       c_mode_load  = 2'd1;
    localparam logic [1:0]       c_mode_count = 2'd2;
    localparam logic [1:0]       c_mode_shift = 2'd3;
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_chg;
    logic [WIDTH-1:0] w_jk_next;
    logic [WIDTH-1:0] w_q_next;

    // Per-bit JK characteristic: Q+ = J&~Q | ~K&Q
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
            assign w_jk_next[gi] = (bus.j[gi] & ~r_q[gi]) | (~bus.k[gi] & r_q[gi]);
        end
    endgenerate

    always_comb begin
        w_q_next = r_q;
        unique case (bus.mode)
            c_mode_jk:    w_q_next = w_jk_next;
            c_mode_load:  w_q_next = bus.d;
            c_mode_count: w_q_next = bus.dir ? (r_q - c_one) : (r_q + c_one);
            c_mode_shift: w_q_next = bus.dir ? {bus.sin, r_q[WIDTH-1:1]}
                                             : {r_q[WIDTH-2:0], bus.sin};
            default:      w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= RST_VAL;
            r_chg <= '0;
        end else if (bus.en) begin
            r_q   <= w_q_next;
            r_chg <= w_q_next ^ r_q;
        end else begin
            r_chg <= '0;
        end
    end

    assign bus.q    = r_q;
    assign bus.qb   = ~r_q;
    assign bus.chg  = r_chg;
    // Flags the cycle just before the counter wraps in the selected direction
    assign bus.tc   = bus.en && (bus.mode == c_mode_count) &&
                      (bus.dir ? (r_q == '0) : (&r_q));
    // The bit that leaves the register on the next shift in direction dir
    assign bus.sout = bus.dir ? r_q[0] : r_q[WIDTH-1];

endmodule
`default_nettype wire
